// File: rtl/modulo_counter.sv
// modulo_counter: up/down counter over 0..MAX with load clamp, wrap/saturate and sticky overflow.
// Optional EN prescaler is compiled in by defining COUNTER_PRESCALE_EN (adds the PDIV port).
module modulo_counter #(
    parameter int WIDTH      = 8,
    parameter bit SATURATE   = 1'b0,
    parameter int PRESCALE_W = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] MAX,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] PDIV,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             OVF
);

    if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_param_check
        $error("modulo_counter: WIDTH must be 2..32 and PRESCALE_W at least 1");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             step_en;
    logic             at_bound;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  presc_term;

    assign presc_term = (presc_q == PDIV);
    assign step_en    = EN & presc_term;

    always_comb begin
        presc_d = presc_q;
        if (LOAD) begin
            presc_d = '0;
        end else if (EN) begin
            presc_d = presc_term ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign step_en = EN;
`endif

    // Up compares with >= so a count left above a lowered MAX still wraps/saturates.
    assign at_bound = UP ? (q_q >= MAX) : (q_q == '0);
    assign CO       = CLR & step_en & ~LOAD & at_bound;

    always_comb begin
        // NOTE: every output gets its hold value first so no path leaves it unassigned (no latch).
        q_d   = q_q;
        ovf_d = ovf_q;
        if (LOAD) begin
            q_d   = (D > MAX) ? MAX : D;
            ovf_d = 1'b0;
        end else if (step_en) begin
            if (at_bound) begin
                ovf_d = 1'b1;
                if (UP) begin
                    q_d = SATURATE ? MAX : '0;
                end else begin
                    q_d = SATURATE ? '0 : MAX;
                end
            end else begin
                q_d = UP ? q_q + 1'b1 : q_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_modulo_counter.sv
// Scoreboard bench: a wrapping 8-bit counter and a saturating 4-bit counter run side by side
// against an arithmetic reference model; a negedge monitor pops and compares expectations.
module tb_modulo_counter;

    localparam int AW = 8;
    localparam int BW = 4;
    localparam int PW = 4;

    logic          CLK = 1'b0;
    logic          CLR, EN, UP, LOAD;
    logic [AW-1:0] a_d, a_max, a_q;
    logic          a_co, a_ovf;
    logic [BW-1:0] b_d, b_max, b_q;
    logic          b_co, b_ovf;
    logic [PW-1:0] pdiv;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    modulo_counter #(.WIDTH(AW), .SATURATE(1'b0), .PRESCALE_W(PW)) u_wrap (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD),
        .D(a_d), .MAX(a_max),
`ifdef COUNTER_PRESCALE_EN
        .PDIV(pdiv),
`endif
        .Q(a_q), .CO(a_co), .OVF(a_ovf)
    );

    modulo_counter #(.WIDTH(BW), .SATURATE(1'b1), .PRESCALE_W(PW)) u_sat (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD),
        .D(b_d), .MAX(b_max),
`ifdef COUNTER_PRESCALE_EN
        .PDIV(pdiv),
`endif
        .Q(b_q), .CO(b_co), .OVF(b_ovf)
    );

    typedef struct { int q; bit ovf; int ps; } mstate_t;
    typedef struct { int q; bit ovf; bit co; } exp_t;

    mstate_t ma = '{0, 1'b0, 0};
    mstate_t mb = '{0, 1'b0, 0};
    exp_t    qa[$];
    exp_t    qb[$];

    // Returns what the DUT shows during this cycle, then advances the model past the next edge.
    function automatic exp_t model(inout mstate_t s, input int d, input int max, input bit sat);
        exp_t e;
        bit   term;
        bit   step;
        if (!CLR) begin
            s = '{0, 1'b0, 0};
            e = '{0, 1'b0, 1'b0};
            return e;
        end
        term = 1'b1;
`ifdef COUNTER_PRESCALE_EN
        term = (s.ps == int'(pdiv));
`endif
        step  = EN && term;
        e.q   = s.q;
        e.ovf = s.ovf;
        e.co  = step && !LOAD && (UP ? (s.q >= max) : (s.q == 0));
        if (LOAD) begin
            s.q   = (d < max) ? d : max;
            s.ovf = 1'b0;
            s.ps  = 0;
        end else begin
            if (EN) s.ps = term ? 0 : (s.ps + 1) % (1 << PW);
            if (step) begin
                if (UP) begin
                    if (s.q < max) s.q = s.q + 1;
                    else begin s.q = sat ? max : 0; s.ovf = 1'b1; end
                end else begin
                    if (s.q > 0) s.q = s.q - 1;
                    else begin s.q = sat ? 0 : max; s.ovf = 1'b1; end
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit clr, input bit en, input bit up, input bit load,
                         input int ad, input int amax, input int bd, input int bmax);
        @(posedge CLK);
        #1;
        CLR   = clr;
        EN    = en;
        UP    = up;
        LOAD  = load;
        a_d   = AW'(ad);
        a_max = AW'(amax);
        b_d   = BW'(bd);
        b_max = BW'(bmax);
        qa.push_back(model(ma, int'(a_d), int'(a_max), 1'b0));
        qb.push_back(model(mb, int'(b_d), int'(b_max), 1'b1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("wrap_q",   32'(a_q),   32'(e.q));
                check("wrap_co",  32'(a_co),  32'(e.co));
                check("wrap_ovf", 32'(a_ovf), 32'(e.ovf));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("sat_q",   32'(b_q),   32'(e.q));
                check("sat_co",  32'(b_co),  32'(e.co));
                check("sat_ovf", 32'(b_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin : stimulus
        CLR = 1'b0; EN = 1'b1; UP = 1'b1; LOAD = 1'b0;
        a_d = '0; a_max = 8'd9; b_d = '0; b_max = 4'd15; pdiv = '0;

        // Held in reset, then count up 0..9 and wrap.
        repeat (3)  drive(0, 1, 1, 0, 0, 9, 0, 15);
        repeat (13) drive(1, 1, 1, 0, 0, 9, 0, 15);

        // Load 2 (wins over EN), then count down through the wrap.
        drive(1, 1, 0, 1, 2, 9, 2, 15);
        repeat (6) drive(1, 1, 0, 0, 2, 9, 2, 15);

        // Saturating counter from 14 upward at MAX=15.
        drive(1, 0, 1, 1, 0, 9, 14, 15);
        repeat (5) drive(1, 1, 1, 0, 0, 9, 14, 15);

        // Load clamp: D above MAX with LOAD and EN together.
        drive(1, 1, 1, 1, 200, 100, 13, 9);
        repeat (3) drive(1, 1, 1, 0, 200, 100, 13, 9);

        // MAX = 0: every step is a bound event.
        repeat (3) drive(1, 1, 1, 0, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0);

        // MAX lowered below Q: hold, then up step and down step from above MAX.
        drive(1, 0, 1, 1, 50, 100, 12, 15);
        repeat (2) drive(1, 0, 1, 0, 50, 10, 12, 5);
        repeat (2) drive(1, 1, 1, 0, 50, 10, 12, 5);
        drive(1, 0, 0, 1, 50, 100, 12, 15);
        drive(1, 0, 0, 0, 50, 10, 12, 5);
        repeat (2) drive(1, 1, 0, 0, 50, 10, 12, 5);

        // Async reset mid-count at Q=5, then release and step once.
        drive(1, 0, 1, 1, 4, 9, 4, 15);
        drive(1, 1, 1, 0, 4, 9, 4, 15);
        drive(1, 0, 1, 0, 4, 9, 4, 15);
        repeat (2) drive(0, 1, 1, 0, 4, 9, 4, 15);
        repeat (3) drive(1, 1, 1, 0, 4, 9, 4, 15);

`ifdef COUNTER_PRESCALE_EN
        // Divide by 4, with a 2-cycle EN gap stretching one interval.
        pdiv = 4'd3;
        drive(1, 1, 1, 1, 0, 200, 0, 15);
        repeat (12) drive(1, 1, 1, 0, 0, 200, 0, 15);
        repeat (2)  drive(1, 0, 1, 0, 0, 200, 0, 15);
        repeat (10) drive(1, 1, 1, 0, 0, 200, 0, 15);
`endif

        // Randomized traffic with small bounds favoured so bound events are frequent.
        begin
            int amax = 9;
            int bmax = 7;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0)
                    amax = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
                if ($urandom_range(0, 19) == 0)
                    bmax = $urandom_range(0, 15);
                if ($urandom_range(0, 49) == 0)
                    pdiv = PW'($urandom_range(0, 3));
                drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 255), amax, $urandom_range(0, 15), bmax);
            end
        end

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge CLK);
        @(posedge CLK);
        check("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/modulo_counter.md
MODULO_COUNTER -- requirements
Module: modulo_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-003 Parameter PRESCALE_W, default 4: prescaler width in bits; used only when COUNTER_PRESCALE_EN is defined.
REQ-004 Port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port CLR, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port EN, input, 1 bit: count enable.
REQ-007 Port UP, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 Port LOAD, input, 1 bit: synchronous load strobe.
REQ-009 Port D, input, WIDTH bits: load value.
REQ-010 Port MAX, input, WIDTH bits: upper bound; the count range is 0..MAX inclusive.
REQ-011 Port PDIV, input, PRESCALE_W bits: prescale divisor minus 1; present only with COUNTER_PRESCALE_EN.
REQ-012 Port Q, output, WIDTH bits: registered count value.
REQ-013 Port CO, output, 1 bit: combinational carry/borrow, for cascading.
REQ-014 Port OVF, output, 1 bit: registered sticky flag recording any wrap or saturation event.

Function
REQ-015 Update priority on each rising CLK edge SHALL be: LOAD first, then step, then hold.
REQ-016 When LOAD=1, Q SHALL take min(D, MAX) on the next edge, OVF SHALL clear, and the prescaler SHALL clear, regardless of EN.
REQ-017 A step SHALL occur on an edge where LOAD=0 and step_en=1; step_en = EN, or EN AND prescaler terminal when prescaling is compiled in.
REQ-018 Up step with Q < MAX SHALL give Q+1.
REQ-019 Down step with Q > 0 SHALL give Q-1.
REQ-020 Up step with Q >= MAX SHALL give 0 when SATURATE=0, or MAX when SATURATE=1, and SHALL set OVF.
REQ-021 Down step with Q == 0 SHALL give MAX when SATURATE=0, or 0 when SATURATE=1, and SHALL set OVF.
REQ-022 CO SHALL equal step_en AND NOT LOAD AND (UP ? Q >= MAX : Q == 0), combinationally in the same cycle as the bound event.
REQ-023 When MAX = 0, Q SHALL remain 0 and every step SHALL assert CO and set OVF.
REQ-024 A MAX change that leaves Q > MAX SHALL not alter Q until the next step or load; that step SHALL follow REQ-020 or REQ-021 as applicable.
REQ-025 When EN=0 and LOAD=0, Q, OVF and the prescaler SHALL hold.
REQ-026 Comparisons SHALL be unsigned WIDTH-bit, and no intermediate value SHALL exceed WIDTH+1 bits.
REQ-027 Latency SHALL be 1 cycle from a LOAD or step edge to the updated Q.

Reset
REQ-028 While CLR=0, Q SHALL be 0, OVF 0 and the prescaler 0, immediately and independent of CLK.
REQ-029 CO SHALL be 0 while CLR=0.
REQ-030 Deassertion of CLR SHALL take effect at the first rising CLK edge after release, with no spurious step on the release edge.
REQ-031 A reset asserted mid-count SHALL discard any pending step or load.

Configuration
REQ-032 Macro COUNTER_PRESCALE_EN defined: a PRESCALE_W-bit prescaler SHALL increment on each EN=1 cycle; terminal = (prescaler == PDIV); at terminal the prescaler SHALL clear and step_en SHALL assert for that cycle.
REQ-033 Macro COUNTER_PRESCALE_EN defined with PDIV = 0: the block SHALL step on every EN cycle.
REQ-034 Macro COUNTER_PRESCALE_EN undefined: no PDIV port and no prescaler logic SHALL exist, and step_en SHALL equal EN.

Verification
REQ-035 Reset: CLR=0 at t=0, then released; EN=1, UP=1, MAX=9 -> Q steps 0,1,...,9,0; CO high in the Q=9 cycle; OVF=1 after the wrap.
REQ-036 Down wrap: LOAD with D=2, MAX=9, then EN=1, UP=0 -> Q 2,1,0,9,8; CO high in the Q=0 cycle.
REQ-037 Saturate: SATURATE=1, WIDTH=4, MAX=15, UP=1 from Q=14 -> Q 15,15,15; OVF=1; CO high each cycle at Q=15.
REQ-038 Load clamp and priority: D=200 with MAX=100 and LOAD=EN=1 together -> Q=100 next cycle, OVF cleared, no step that cycle.
REQ-039 Async reset mid-count: at Q=5, drop CLR between edges -> Q=0 and OVF=0 before the next edge; Q=1 one edge after CLR release.
REQ-040 Prescale (macro defined): PDIV=3, EN=1, UP=1 -> Q increments once every 4 cycles; EN=0 for 2 cycles stretches that interval to 6 cycles.
